// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT output reorder path.
package fft_pkg;

  localparam int DEF_DATA_WIDTH = 12;
  localparam int DEF_N_POINTS   = 16;
  localparam int MAX_LOG2N      = 10;

  typedef struct packed {
    logic signed [DEF_DATA_WIDTH-1:0] re;
    logic signed [DEF_DATA_WIDTH-1:0] im;
  } cplx_t;

  // Reverse the low log2n bits of idx; bits above log2n must be zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                  input int                   log2n);
    logic [MAX_LOG2N-1:0] mirrored;
    mirrored = {<<{idx}};
    return mirrored >> (MAX_LOG2N - log2n);
  endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample store: one write port, one read port with a registered read.
module fft_pingpong_ram #(
  parameter int DATA_W = 24,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  // NOTE: the storage array has no reset so it can map onto block RAM; only the read register is reset.
  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// Ping-pong reorder buffer: bit-reversed (or in-order) frames in, natural-order frames out.
module fft_bitrev_reorder
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_POINTS   = DEF_N_POINTS
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         stall,
  input  logic                         valid_in,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] x_r,
  input  logic signed [DATA_WIDTH-1:0] x_i,
  input  logic                         reorder_en,
  output logic                         valid_out,
  input  logic                         out_ready,
  output logic signed [DATA_WIDTH-1:0] X_r,
  output logic signed [DATA_WIDTH-1:0] X_i,
  output logic                         sop_out,
  output logic                         eop_out
);

  localparam int LOG2N = $clog2(N_POINTS);
  localparam int AW    = LOG2N + 1;

  typedef logic [LOG2N-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(N_POINTS - 1);

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] re;
    logic signed [DATA_WIDTH-1:0] im;
  } sample_t;

  idx_t       wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic       wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0] full_q, full_d, mode_q, mode_d;
  logic       valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;

  logic       accept, advance, rd_load, wr_last, rd_last, wr_mode;
  idx_t       wr_addr;
  sample_t    wr_sample, rd_sample;
  logic [2*DATA_WIDTH-1:0] rd_data;

  assign in_ready = !full_q[wr_bank_q];
  assign accept   = valid_in && in_ready && !stall;
  assign advance  = !stall && (!valid_q || out_ready);
  assign rd_load  = advance && full_q[rd_bank_q];
  assign wr_last  = (wr_idx_q == LAST_IDX);
  assign rd_last  = (rd_idx_q == LAST_IDX);

  // The first sample of a frame carries its own mode; later samples use the latched bit.
  assign wr_mode   = (wr_idx_q == '0) ? reorder_en : mode_q[wr_bank_q];
  assign wr_addr   = wr_mode ? idx_t'(bitrev(MAX_LOG2N'(wr_idx_q), LOG2N)) : wr_idx_q;
  assign wr_sample = '{re: x_r, im: x_i};

  always_comb begin
    // NOTE: every next-state value gets a default first, so no path leaves a latch behind.
    wr_idx_d  = wr_idx_q;
    wr_bank_d = wr_bank_q;
    rd_idx_d  = rd_idx_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    mode_d    = mode_q;
    valid_d   = valid_q;
    sop_d     = sop_q;
    eop_d     = eop_q;

    if (accept) begin
      if (wr_idx_q == '0) mode_d[wr_bank_q] = reorder_en;
      if (wr_last) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = !wr_bank_q;
        wr_idx_d          = '0;
      end else begin
        wr_idx_d = wr_idx_q + idx_t'(1);
      end
    end

    // Writer only touches a non-full bank and reader only a full one, so the two never collide.
    if (advance) begin
      valid_d = full_q[rd_bank_q];
      if (rd_load) begin
        sop_d = (rd_idx_q == '0);
        eop_d = rd_last;
        if (rd_last) begin
          full_d[rd_bank_q] = 1'b0;
          rd_bank_d         = !rd_bank_q;
          rd_idx_d          = '0;
        end else begin
          rd_idx_d = rd_idx_q + idx_t'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses <= so every flop samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_idx_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_idx_q  <= '0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      mode_q    <= '0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
    end else begin
      wr_idx_q  <= wr_idx_d;
      wr_bank_q <= wr_bank_d;
      rd_idx_q  <= rd_idx_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
    end
  end

  // The RAM read register doubles as the output data register.
  fft_pingpong_ram #(
    .DATA_W (2*DATA_WIDTH),
    .ADDR_W (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (accept),
    .waddr_i ({wr_bank_q, wr_addr}),
    .wdata_i (wr_sample),
    .re_i    (rd_load),
    .raddr_i ({rd_bank_q, rd_idx_q}),
    .rdata_o (rd_data)
  );

  assign rd_sample = rd_data;
  assign X_r       = rd_sample.re;
  assign X_i       = rd_sample.im;
  assign valid_out = valid_q;
  assign sop_out   = sop_q;
  assign eop_out   = eop_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Self-checking bench: frame-level reference model (bit-reverse permutation) against two DUT sizes.
module tb_fft_bitrev_reorder;

  localparam int N    = 16;
  localparam int DW   = 12;
  localparam int N64  = 64;
  localparam int DW64 = 16;
  localparam int F64  = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, stall, valid_in, reorder_en, out_ready;
  logic signed [DW-1:0] x_r, x_i, X_r, X_i;
  logic                 in_ready, valid_out, sop_out, eop_out;

  logic                   stall64, valid_in64, reorder_en64, out_ready64;
  logic signed [DW64-1:0] x_r64, x_i64, X_r64, X_i64;
  logic                   in_ready64, valid_out64, sop_out64, eop_out64;

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(N)) dut (
    .clk(clk), .rst(rst), .stall(stall), .valid_in(valid_in), .in_ready(in_ready),
    .x_r(x_r), .x_i(x_i), .reorder_en(reorder_en), .valid_out(valid_out),
    .out_ready(out_ready), .X_r(X_r), .X_i(X_i), .sop_out(sop_out), .eop_out(eop_out)
  );

  fft_bitrev_reorder #(.DATA_WIDTH(DW64), .N_POINTS(N64)) dut64 (
    .clk(clk), .rst(rst), .stall(stall64), .valid_in(valid_in64), .in_ready(in_ready64),
    .x_r(x_r64), .x_i(x_i64), .reorder_en(reorder_en64), .valid_out(valid_out64),
    .out_ready(out_ready64), .X_r(X_r64), .X_i(X_i64), .sop_out(sop_out64), .eop_out(eop_out64)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Position k of a natural-order frame holds input sample bitrev(k).
  function automatic int tb_bitrev(input int v, input int bits);
    int r = 0;
    for (int b = 0; b < bits; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  typedef struct { int re; int im; bit sop; bit eop; } exp_t;
  exp_t exp_q[$];
  int   cur_r[$], cur_i[$];
  bit   cur_mode;
  int   out_log[$];
  int   accepts, run_len, max_run, ready_low;
  bit   hold_prev;
  int   prev_r, prev_i;
  bit   prev_sop;

  // Monitor for the N=16 instance: handshakes are evaluated at the negedge before the edge that completes them.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete(); cur_r.delete(); cur_i.delete();
      hold_prev = 1'b0;
      run_len   = 0;
    end else begin
      if (hold_prev) begin
        check("hold_valid", valid_out, 1);
        check("hold_X_r", X_r, prev_r);
        check("hold_X_i", X_i, prev_i);
        check("hold_sop", sop_out, prev_sop);
      end
      hold_prev = valid_out && !(out_ready && !stall);
      prev_r = X_r; prev_i = X_i; prev_sop = sop_out;

      run_len = valid_out ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (!in_ready) ready_low++;

      if (valid_out && out_ready && !stall) begin
        out_log.push_back(int'(X_r));
        if (exp_q.size() == 0) begin
          check("unexpected_output", exp_q.size(), 1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("X_r", X_r, e.re);
          check("X_i", X_i, e.im);
          check("sop_out", sop_out, e.sop);
          check("eop_out", eop_out, e.eop);
        end
      end

      if (valid_in && in_ready && !stall) begin
        if (cur_r.size() == 0) cur_mode = reorder_en;
        cur_r.push_back(int'(x_r));
        cur_i.push_back(int'(x_i));
        accepts++;
        if (cur_r.size() == N) begin
          for (int k = 0; k < N; k++) begin
            int j;
            j = cur_mode ? tb_bitrev(k, 4) : k;
            exp_q.push_back('{re: cur_r[j], im: cur_i[j], sop: (k == 0), eop: (k == N - 1)});
          end
          cur_r.delete(); cur_i.delete();
        end
      end
    end
  end

  task automatic push(input int r, input int im, input bit mode);
    bit ok = 1'b0;
    valid_in   = 1'b1;
    x_r        = DW'(r);
    x_i        = DW'(im);
    reorder_en = mode;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      if (in_ready && !stall) ok = 1'b1;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    check("accept_wait", ok, 1);
  endtask

  // kind 1: ramp x_r=base+i, x_i=-x_r; kind 0: random full-range data.
  task automatic send_frame(input bit mode, input int kind, input int base);
    for (int i = 0; i < N; i++) begin
      if (kind == 1) push(base + i, -(base + i), mode);
      else           push(int'($urandom_range(0, 4095)) - 2048, int'($urandom_range(0, 4095)) - 2048, mode);
    end
  endtask

  task automatic drain(input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && cur_r.size() == 0 && !valid_out) done = 1'b1;
    end
    check(tag, done, 1);
  endtask

  int golden [N] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
  int in_r64 [F64*N64];
  int in_i64 [F64*N64];
  bit modes64 [F64] = '{1'b1, 1'b0, 1'b1};
  int got_r[$], got_i[$], got_fl[$];

  initial begin
    rst = 1'b1; stall = 1'b0; valid_in = 1'b0; reorder_en = 1'b0; out_ready = 1'b1;
    x_r = '0; x_i = '0;
    stall64 = 1'b0; valid_in64 = 1'b0; reorder_en64 = 1'b0; out_ready64 = 1'b1;
    x_r64 = '0; x_i64 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", valid_out, 0);
    check("rst_X_r", X_r, 0);
    check("rst_X_i", X_i, 0);
    check("rst_sop", sop_out, 0);
    check("rst_eop", eop_out, 0);
    check("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp frame, bit-reverse mode, with latency check.
    out_log.delete();
    send_frame(1'b1, 1, 0);
    @(negedge clk);
    check("lat_edge_T", valid_out, 0);
    @(negedge clk);
    check("lat_edge_T1_valid", valid_out, 1);
    check("lat_edge_T1_X_r", X_r, 0);
    check("lat_edge_T1_sop", sop_out, 1);
    drain("t1_drain");
    check("t1_count", out_log.size(), N);
    for (int i = 0; i < N && i < out_log.size(); i++) check("t1_order", out_log[i], golden[i]);

    // Back-to-back pass-through then reorder frames.
    max_run = 0; run_len = 0; ready_low = 0;
    send_frame(1'b0, 0, 0);
    send_frame(1'b1, 0, 0);
    drain("t2_drain");
    check("t2_contiguous", max_run, 2 * N);
    check("t2_in_ready_low", ready_low, 0);

    // Back-pressure: three frames offered while the output is blocked.
    accepts = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int f = 0; f < 3; f++) send_frame(1'b0, 1, f * N);
      end
      begin
        repeat (40) @(posedge clk);
        #2;
        check("t3_accepts", accepts, 2 * N);
        check("t3_in_ready", in_ready, 0);
        check("t3_valid_out", valid_out, 1);
        check("t3_X_r", X_r, 0);
        check("t3_sop", sop_out, 1);
        out_ready = 1'b1;
      end
    join
    drain("t3_drain");
    check("t3_total_accepts", accepts, 3 * N);

    // Global stall mid-frame on both sides.
    fork
      begin
        send_frame(1'b1, 0, 0);
        send_frame(1'b1, 0, 0);
      end
      begin
        repeat (22) @(posedge clk);
        #1 stall = 1'b1;
        check("t4_valid_at_stall", valid_out, 1);
        repeat (5) @(posedge clk);
        #1 stall = 1'b0;
      end
    join
    drain("t4_drain");

    // Asynchronous reset at sample 7 of a frame while the previous frame streams out.
    send_frame(1'b1, 0, 0);
    for (int i = 0; i < 7; i++) push(int'($urandom_range(0, 4095)) - 2048, i, 1'b1);
    check("t5_pre_valid", valid_out, 1);
    rst = 1'b1;
    #1;
    check("t5_rst_valid_out", valid_out, 0);
    check("t5_rst_X_r", X_r, 0);
    check("t5_rst_X_i", X_i, 0);
    check("t5_rst_sop", sop_out, 0);
    check("t5_rst_in_ready", in_ready, 1);
    @(negedge clk);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    send_frame(1'b1, 0, 0);
    drain("t5_drain");

    // N=64, 16-bit: random frames including the extreme codes.
    for (int k = 0; k < F64 * N64; k++) begin
      in_r64[k] = int'($urandom_range(0, 65535)) - 32768;
      in_i64[k] = int'($urandom_range(0, 65535)) - 32768;
    end
    in_r64[0] = -32768;  in_i64[0] = 32767;
    in_r64[70] = 32767;  in_i64[70] = -32768;
    in_r64[191] = 32767; in_i64[191] = 32767;
    in_r64[129] = -32768; in_i64[129] = -32768;
    begin
      int k = 0;
      for (int c = 0; c < 2000 && got_r.size() < F64 * N64; c++) begin
        @(posedge clk); #1;
        valid_in64 = (k < F64 * N64);
        if (k < F64 * N64) begin
          x_r64        = DW64'(in_r64[k]);
          x_i64        = DW64'(in_i64[k]);
          reorder_en64 = modes64[k / N64];
        end
        @(negedge clk);
        if (valid_out64) begin
          got_r.push_back(int'(X_r64));
          got_i.push_back(int'(X_i64));
          got_fl.push_back({30'd0, sop_out64, eop_out64});
        end
        if (valid_in64 && in_ready64) k++;
      end
      valid_in64 = 1'b0;
    end
    check("t6_count", got_r.size(), F64 * N64);
    for (int f = 0; f < F64; f++) begin
      for (int j = 0; j < N64; j++) begin
        int idx, src;
        idx = f * N64 + j;
        src = f * N64 + (modes64[f] ? tb_bitrev(j, 6) : j);
        if (idx < got_r.size()) begin
          check("t6_X_r", got_r[idx], in_r64[src]);
          check("t6_X_i", got_i[idx], in_i64[src]);
          check("t6_sop_eop", got_fl[idx], (j == 0) * 2 + (j == N64 - 1));
        end
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
